// File: rtl/corr_peak_detector.sv
// Per-sweep peak search over a stream of unsigned correlation values; reports {max, lag} via valid/ready.
// Optional build macro CORR_THRESHOLD_EN adds a threshold port captured at start and drives peak_above.
module corr_peak_detector #(
    parameter int WIDTH    = 256,
    parameter int C_WIDTH  = 8,
    parameter int NUM_LAGS = (1 << C_WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [C_WIDTH-1:0] in_lag,
    input  logic [WIDTH-1:0]   in_value,
    input  logic               in_last,
    output logic               peak_valid,
    input  logic               peak_ready,
    output logic [WIDTH-1:0]   peak_value,
    output logic [C_WIDTH-1:0] peak_lag,
    output logic               peak_above,
    output logic               busy,
    output logic               order_err
`ifdef CORR_THRESHOLD_EN
    ,
    input  logic [WIDTH-1:0]   threshold
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam logic [C_WIDTH:0] LAST_CNT = (C_WIDTH+1)'(NUM_LAGS - 1);

    state_t             state, state_n;
    logic [WIDTH-1:0]   max_q;
    logic [C_WIDTH-1:0] lag_q;
    logic [C_WIDTH:0]   cnt_q;
    logic               seen_q;
    logic               oerr_q;
    logic               accept;
    logic               close;
`ifdef CORR_THRESHOLD_EN
    logic [WIDTH-1:0]   thr_q;
`endif

    assign accept = in_valid && in_ready;
    assign close  = accept && (in_last || (cnt_q == LAST_CNT));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start)      state_n = SCAN;
            SCAN:    if (close)      state_n = REPORT;
            REPORT:  if (peak_ready) state_n = IDLE;
            default:                 state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == SCAN);
        peak_valid = (state == REPORT);
        busy       = (state != IDLE);
`ifdef CORR_THRESHOLD_EN
        peak_above = (state == REPORT) && (max_q >= thr_q);
`else
        peak_above = (state == REPORT);
`endif
    end

    // Running max: strict '>' keeps the earliest lag on ties; seen forces capture of the first sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_q  <= '0;
            lag_q  <= '0;
            cnt_q  <= '0;
            seen_q <= 1'b0;
            oerr_q <= 1'b0;
        end else if (state == IDLE && start) begin
            max_q  <= '0;
            lag_q  <= '0;
            cnt_q  <= '0;
            seen_q <= 1'b0;
            oerr_q <= 1'b0;
        end else if (accept) begin
            if (!seen_q || in_value > max_q) begin
                max_q <= in_value;
                lag_q <= in_lag;
            end
            seen_q <= 1'b1;
            if ({1'b0, in_lag} != cnt_q) oerr_q <= 1'b1;
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef CORR_THRESHOLD_EN
    always_ff @(posedge clk) begin
        if (reset)                    thr_q <= '0;
        else if (state == IDLE && start) thr_q <= threshold;
    end
`endif

    assign peak_value = max_q;
    assign peak_lag   = lag_q;
    assign order_err  = oerr_q;

endmodule

// File: tb/tb_corr_peak_detector.sv
// Self-checking bench for corr_peak_detector: table of sweeps, scoreboard on report, plus corner sequences.
module tb_corr_peak_detector;

    localparam int WIDTH    = 256;
    localparam int C_WIDTH  = 8;
    localparam int NUM_LAGS = (1 << C_WIDTH);
    localparam int NVEC     = 7;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [C_WIDTH-1:0] in_lag = '0;
    logic [WIDTH-1:0]   in_value = '0;
    logic               in_last = 1'b0;
    logic               peak_valid;
    logic               peak_ready = 1'b0;
    logic [WIDTH-1:0]   peak_value;
    logic [C_WIDTH-1:0] peak_lag;
    logic               peak_above;
    logic               busy;
    logic               order_err;
`ifdef CORR_THRESHOLD_EN
    logic [WIDTH-1:0]   threshold = WIDTH'(10);
`endif

    corr_peak_detector #(.WIDTH(WIDTH), .C_WIDTH(C_WIDTH), .NUM_LAGS(NUM_LAGS)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_lag(in_lag),
        .in_value(in_value), .in_last(in_last),
        .peak_valid(peak_valid), .peak_ready(peak_ready),
        .peak_value(peak_value), .peak_lag(peak_lag), .peak_above(peak_above),
        .busy(busy), .order_err(order_err)
`ifdef CORR_THRESHOLD_EN
        , .threshold(threshold)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]                n;
        logic [3:0][C_WIDTH-1:0]   lags;
        logic [3:0][WIDTH-1:0]     vals;
        logic [WIDTH-1:0]          exp_val;
        logic [C_WIDTH-1:0]        exp_lag;
        logic                      exp_oerr;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0]   v;
        logic [C_WIDTH-1:0] l;
        logic               oe;
        logic               ab;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sbq  [$];
    int   checks = 0;
    int   failures = 0;
    logic pv_q = 1'b0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_above(input logic [WIDTH-1:0] v);
`ifdef CORR_THRESHOLD_EN
        return v >= threshold;
`else
        return (v == v);
`endif
    endfunction

    function automatic vec_t mk(input int n,
                                input int l0, input int l1, input int l2, input int l3,
                                input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1,
                                input logic [WIDTH-1:0] v2, input logic [WIDTH-1:0] v3,
                                input logic [WIDTH-1:0] ev, input int el, input logic eo);
        vec_t r;
        r.n = 8'(n);
        r.lags[0] = C_WIDTH'(l0); r.lags[1] = C_WIDTH'(l1);
        r.lags[2] = C_WIDTH'(l2); r.lags[3] = C_WIDTH'(l3);
        r.vals[0] = v0; r.vals[1] = v1; r.vals[2] = v2; r.vals[3] = v3;
        r.exp_val = ev; r.exp_lag = C_WIDTH'(el); r.exp_oerr = eo;
        return r;
    endfunction

    // Scoreboard: each rising edge of peak_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (peak_valid && !pv_q) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_report: got value %0h lag %0d with nothing expected", peak_value, peak_lag);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_peak_value", peak_value, e.v);
                chk("sb_peak_lag", WIDTH'(peak_lag), WIDTH'(e.l));
                chk("sb_order_err", WIDTH'(order_err), WIDTH'(e.oe));
                chk("sb_peak_above", WIDTH'(peak_above), WIDTH'(e.ab));
            end
        end
        pv_q <= peak_valid;
    end

    task automatic push_exp(input logic [WIDTH-1:0] v, input int l, input logic oe);
        exp_t e;
        e.v = v; e.l = C_WIDTH'(l); e.oe = oe; e.ab = exp_above(v);
        sbq.push_back(e);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", WIDTH'(busy), WIDTH'(1));
        chk("start_in_ready", WIDTH'(in_ready), WIDTH'(1));
        chk("start_value_cleared", peak_value, '0);
        chk("start_oerr_cleared", WIDTH'(order_err), '0);
    endtask

    task automatic send(input int lag, input logic [WIDTH-1:0] val, input logic last);
        in_valid = 1'b1; in_lag = C_WIDTH'(lag); in_value = val; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic release_report();
        peak_ready = 1'b1;
        @(posedge clk); #1;
        peak_ready = 1'b0;
        chk("release_busy", WIDTH'(busy), '0);
        chk("release_peak_valid", WIDTH'(peak_valid), '0);
        chk("release_peak_above", WIDTH'(peak_above), '0);
    endtask

    task automatic run_vec(input vec_t v);
        do_start();
        push_exp(v.exp_val, int'(v.exp_lag), v.exp_oerr);
        for (int i = 0; i < int'(v.n); i++) begin
            if (i == int'(v.n) - 1) chk("pre_close_peak_valid", WIDTH'(peak_valid), '0);
            send(int'(v.lags[i]), v.vals[i], (i == int'(v.n) - 1));
        end
        chk("latency_peak_valid", WIDTH'(peak_valid), WIDTH'(1));
        chk("report_in_ready", WIDTH'(in_ready), '0);
    endtask

    initial begin
        logic [WIDTH-1:0] top_bit;
        logic [WIDTH-1:0] below_top;
        top_bit   = {1'b1, {(WIDTH-1){1'b0}}};
        below_top = {1'b0, {(WIDTH-1){1'b1}}};

        vecs[0] = mk(4, 0, 1, 2, 3, 5, 9, 2, 9, 9, 1, 1'b0);
        vecs[1] = mk(1, 0, 0, 0, 0, 7, 0, 0, 0, 7, 0, 1'b0);
        vecs[2] = mk(3, 5, 6, 7, 0, 0, 0, 0, 0, 0, 5, 1'b1);
        vecs[3] = mk(3, 0, 1, 3, 0, 4, 8, 6, 0, 8, 1, 1'b1);
        vecs[4] = mk(4, 0, 1, 2, 3, 1, 2, 3, 100, 100, 3, 1'b0);
        vecs[5] = mk(3, 0, 1, 2, 0, below_top, top_bit, top_bit, 0, top_bit, 1, 1'b0);
        vecs[6] = mk(2, 0, 1, 0, 0, 9, 10, 0, 0, 10, 1, 1'b0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_peak_valid", WIDTH'(peak_valid), '0);
        chk("rst_in_ready", WIDTH'(in_ready), '0);
        chk("rst_busy", WIDTH'(busy), '0);
        chk("rst_order_err", WIDTH'(order_err), '0);
        chk("rst_peak_value", peak_value, '0);
        chk("rst_peak_lag", WIDTH'(peak_lag), '0);
        chk("rst_peak_above", WIDTH'(peak_above), '0);

        // Hold the result in REPORT with start pulses that must be ignored.
        run_vec(vecs[0]);
        for (int k = 0; k < 10; k++) begin
            start = (k % 3 == 0);
            @(posedge clk); #1;
            start = 1'b0;
            chk("hold_peak_valid", WIDTH'(peak_valid), WIDTH'(1));
            chk("hold_in_ready", WIDTH'(in_ready), '0);
            chk("hold_peak_value", peak_value, WIDTH'(9));
            chk("hold_peak_lag", WIDTH'(peak_lag), WIDTH'(1));
            chk("hold_peak_above", WIDTH'(peak_above), WIDTH'(exp_above(WIDTH'(9))));
        end
        release_report();
        chk("idle_keeps_value", peak_value, WIDTH'(9));
        chk("idle_keeps_lag", WIDTH'(peak_lag), WIDTH'(1));

        for (int v = 0; v < NVEC; v++) begin
            run_vec(vecs[v]);
            release_report();
        end

        // Auto-close after NUM_LAGS samples without in_last.
        do_start();
        push_exp(WIDTH'(NUM_LAGS - 1), NUM_LAGS - 1, 1'b0);
        for (int i = 0; i < NUM_LAGS; i++) begin
            if (i == NUM_LAGS - 1) chk("auto_pre_close", WIDTH'(peak_valid), '0);
            send(i, WIDTH'(i), 1'b0);
        end
        chk("auto_close_peak_valid", WIDTH'(peak_valid), WIDTH'(1));
        release_report();

        // order_err timing: set the cycle after the out-of-order sample, cleared by next start.
        do_start();
        push_exp(WIDTH'(3), 3, 1'b1);
        send(0, WIDTH'(1), 1'b0);
        send(1, WIDTH'(2), 1'b0);
        chk("oerr_before", WIDTH'(order_err), '0);
        send(3, WIDTH'(3), 1'b0);
        chk("oerr_after", WIDTH'(order_err), WIDTH'(1));
        send(4, WIDTH'(1), 1'b1);
        chk("oerr_report", WIDTH'(peak_valid), WIDTH'(1));
        release_report();
        chk("oerr_sticky_idle", WIDTH'(order_err), WIDTH'(1));
        do_start();
        push_exp(WIDTH'(1), 0, 1'b0);
        send(0, WIDTH'(1), 1'b1);
        release_report();

        // Reset mid-sweep discards the partial result.
        do_start();
        send(0, WIDTH'(50), 1'b0);
        send(1, WIDTH'(60), 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", WIDTH'(busy), '0);
        chk("midrst_peak_valid", WIDTH'(peak_valid), '0);
        chk("midrst_peak_value", peak_value, '0);
        chk("midrst_peak_lag", WIDTH'(peak_lag), '0);
        chk("midrst_in_ready", WIDTH'(in_ready), '0);
        chk("midrst_peak_above", WIDTH'(peak_above), '0);
        repeat (3) @(posedge clk);
        #1 chk("midrst_no_report", WIDTH'(peak_valid), '0);
        run_vec(vecs[4]);
        release_report();

        repeat (2) @(posedge clk);
        #1 chk("sb_drained", WIDTH'(sbq.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
